// File: rtl/otter_iobus_uart_tx_if.sv
// OTTER IOBUS bundle: the CPU drives address, write data and strobe.
// The peripheral returns read data on IOBUS_IN.
interface otter_iobus_uart_tx_if;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;

    modport master (
        output IOBUS_ADDR,
        output IOBUS_OUT,
        output IOBUS_WR,
        input  IOBUS_IN
    );

    modport slave (
        input  IOBUS_ADDR,
        input  IOBUS_OUT,
        input  IOBUS_WR,
        output IOBUS_IN
    );
endinterface

// File: rtl/otter_iobus_uart_tx.sv
// IOBUS-mapped 8N1 UART transmitter with a transmit FIFO, a status register
// and a programmable baud divisor (clocks per bit).
module otter_iobus_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic                   CLK,
    input  logic                   RESET,
    otter_iobus_uart_tx_if.slave   bus,
    output logic                   TX,
    output logic                   IRQ
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_next;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow, irq_en;
    logic [15:0]       baud_div;
    logic [15:0]       div_cnt, div_cnt_next;
    logic [2:0]        bit_cnt, bit_cnt_next;
    logic [7:0]        shift, shift_next;
    logic              tx_next;
    logic              pop;
    logic              hit;
    logic [1:0]        sel;
    logic              push_req, push;
    logic              fifo_empty, fifo_full;
    logic              bit_end;
    logic              status_wr, baud_wr;
    logic [31:0]       status_word, rdata_next;

    assign hit        = (bus.IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign sel        = bus.IOBUS_ADDR[3:2];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign push_req   = bus.IOBUS_WR && hit && (sel == 2'd0);
    assign status_wr  = bus.IOBUS_WR && hit && (sel == 2'd1);
    assign baud_wr    = bus.IOBUS_WR && hit && (sel == 2'd2);
    // A full FIFO still accepts a push when the shifter pops in the same cycle.
    assign push       = push_req && (!fifo_full || pop);
    // Compared against the live divisor so a mid-bit shrink ends the bit at once.
    assign bit_end    = (div_cnt >= (baud_div - 16'd1));
    assign IRQ        = fifo_empty && (state == IDLE) && irq_en;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= bus.IOBUS_OUT[7:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            baud_div <= DEFAULT_DIV;
        end else begin
            if (push_req && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (status_wr && bus.IOBUS_OUT[3]) begin
                overflow <= 1'b0;
            end
            if (status_wr) begin
                irq_en <= bus.IOBUS_OUT[4];
            end
            if (baud_wr) begin
                baud_div <= (bus.IOBUS_OUT[15:0] == 16'd0) ? 16'd1 : bus.IOBUS_OUT[15:0];
            end
        end
    end

    always_comb begin
        status_word       = '0;
        status_word[0]    = (state != IDLE) || !fifo_empty;
        status_word[1]    = fifo_full;
        status_word[2]    = fifo_empty;
        status_word[3]    = overflow;
        status_word[4]    = irq_en;
        status_word[11:8] = 4'(count);
        rdata_next        = '0;
        if (hit) begin
            case (sel)
                2'd1:    rdata_next = status_word;
                2'd2:    rdata_next = {16'h0000, baud_div};
                default: rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus.IOBUS_IN <= '0;
        end else begin
            bus.IOBUS_IN <= rdata_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            TX      <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            TX      <= tx_next;
            div_cnt <= div_cnt_next;
            bit_cnt <= bit_cnt_next;
            shift   <= shift_next;
        end
    end

    // TX is registered, so tx_next is the level the line takes after this edge.
    always_comb begin
        state_next   = state;
        tx_next      = TX;
        div_cnt_next = div_cnt + 16'd1;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        pop          = 1'b0;
        if (bit_end) begin
            div_cnt_next = '0;
        end
        case (state)
            IDLE: begin
                div_cnt_next = '0;
                bit_cnt_next = '0;
                tx_next      = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                    tx_next      = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next   = shift >> 1;
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        tx_next = shift[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_otter_iobus_uart_tx.sv
// Self-checking bench: register vectors, a serial-line decoder scoreboard
// and hand-written sequences for the framing and FIFO corner cases.
module tb_otter_iobus_uart_tx;

    localparam logic [31:0] A_TX = 32'h1100_0100;
    localparam logic [31:0] A_ST = 32'h1100_0104;
    localparam logic [31:0] A_BD = 32'h1100_0108;
    localparam logic [31:0] A_C  = 32'h1100_010C;

    logic CLK;
    logic RESET;
    logic TX;
    logic IRQ;

    otter_iobus_uart_tx_if bus ();

    otter_iobus_uart_tx dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave),
        .TX    (TX),
        .IRQ   (IRQ)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] expected;
    } vec_t;

    vec_t        vecs [17];
    int          checks = 0;
    int          errors = 0;
    int          cycleCount = 0;
    int          monDiv = 868;
    int          startq [$];
    logic [7:0]  rxq [$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        forever begin
            @(posedge CLK);
            cycleCount = cycleCount + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] data);
        bus.IOBUS_ADDR = addr;
        bus.IOBUS_WR   = wr;
        bus.IOBUS_OUT  = data;
        @(posedge CLK);
        #1;
        bus.IOBUS_WR   = 1'b0;
        bus.IOBUS_ADDR = 32'h0;
        bus.IOBUS_OUT  = 32'h0;
    endtask

    task automatic applyReset();
        RESET = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        rxq.delete();
        startq.delete();
        monDiv = 868;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Line decoder: samples each bit at its centre, using the divisor the bench last programmed.
    initial begin
        int pos;
        logic inFrame;
        logic [7:0] rxByte;
        inFrame = 1'b0;
        pos = 0;
        rxByte = '0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                inFrame = 1'b0;
            end else if (!inFrame) begin
                if (TX == 1'b0) begin
                    inFrame = 1'b1;
                    pos = 0;
                    rxByte = '0;
                    startq.push_back(cycleCount);
                end
            end else begin
                pos = pos + 1;
                for (int i = 0; i < 8; i++) begin
                    if (pos == monDiv * (i + 1) + monDiv / 2) rxByte[i] = TX;
                end
                if (pos == 9 * monDiv + monDiv / 2) checkOutput("stopBit", 32'(TX), 32'h1);
                if (pos == 10 * monDiv - 1) begin
                    inFrame = 1'b0;
                    rxq.push_back(rxByte);
                end
            end
        end
    end

    initial begin
        int n;
        int div;
        int lows;
        logic [7:0] expBytes [$];
        logic [7:0] b;
        logic expTx;
        int bitIdx;
        logic [7:0] pattern;

        RESET = 1'b1;
        bus.IOBUS_ADDR = 32'h0;
        bus.IOBUS_OUT  = 32'h0;
        bus.IOBUS_WR   = 1'b0;

        vecs[0]  = '{A_ST, 1'b0, 32'h0, 1'b1, 32'h0000_0004};
        vecs[1]  = '{A_BD, 1'b0, 32'h0, 1'b1, 32'd868};
        vecs[2]  = '{A_TX, 1'b0, 32'h0, 1'b1, 32'h0};
        vecs[3]  = '{A_C,  1'b0, 32'h0, 1'b1, 32'h0};
        vecs[4]  = '{32'h1100_0200, 1'b0, 32'h0, 1'b1, 32'h0};
        vecs[5]  = '{A_BD, 1'b1, 32'h0, 1'b0, 32'h0};
        vecs[6]  = '{A_BD, 1'b0, 32'h0, 1'b1, 32'h1};
        vecs[7]  = '{A_BD, 1'b1, 32'hABCD_1234, 1'b0, 32'h0};
        vecs[8]  = '{A_BD, 1'b0, 32'h0, 1'b1, 32'h0000_1234};
        vecs[9]  = '{A_ST, 1'b1, 32'hFFFF_FFF7, 1'b0, 32'h0};
        vecs[10] = '{A_ST, 1'b0, 32'h0, 1'b1, 32'h0000_0014};
        vecs[11] = '{A_ST, 1'b1, 32'h0, 1'b0, 32'h0};
        vecs[12] = '{A_ST, 1'b0, 32'h0, 1'b1, 32'h0000_0004};
        vecs[13] = '{A_C,  1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[14] = '{A_C,  1'b0, 32'h0, 1'b1, 32'h0};
        vecs[15] = '{32'h1100_0000, 1'b1, 32'h41, 1'b0, 32'h0};
        vecs[16] = '{A_ST, 1'b0, 32'h0, 1'b1, 32'h0000_0004};

        applyReset();
        checkOutput("resetIobusIn", bus.IOBUS_IN, 32'h0);
        checkOutput("resetTx", 32'(TX), 32'h1);
        checkOutput("resetIrq", 32'(IRQ), 32'h0);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wr, vecs[i].wdata);
            if (vecs[i].chk) checkOutput($sformatf("vec%0d", i), bus.IOBUS_IN, vecs[i].expected);
        end

        // Single frame, divisor 4: TX waveform edge by edge plus busy clearing.
        applyStimulus(A_BD, 1'b1, 32'd4);
        monDiv = 4;
        rxq.delete();
        startq.delete();
        pattern = 8'h55;
        applyStimulus(A_TX, 1'b1, {24'h0, pattern});
        checkOutput("txIdleAtWriteEdge", 32'(TX), 32'h1);
        bus.IOBUS_ADDR = A_ST;
        for (int k = 1; k <= 42; k++) begin
            @(posedge CLK);
            #1;
            bitIdx = (k - 1) / 4;
            if (k <= 41) begin
                if (bitIdx == 0)      expTx = 1'b0;
                else if (bitIdx <= 8) expTx = pattern[bitIdx - 1];
                else                  expTx = 1'b1;
                checkOutput($sformatf("tx55_k%0d", k), 32'(TX), 32'(expTx));
            end
            if (k == 41) checkOutput("busyBeforeEnd", 32'(bus.IOBUS_IN[0]), 32'h1);
            if (k == 42) checkOutput("busyAfterEnd", 32'(bus.IOBUS_IN[0]), 32'h0);
        end
        bus.IOBUS_ADDR = 32'h0;
        checkOutput("rx55Count", 32'(rxq.size()), 32'h1);
        if (rxq.size() > 0) checkOutput("rx55Byte", 32'(rxq[0]), 32'h55);

        // Back-to-back frames with divisor 2 must be contiguous.
        applyStimulus(A_BD, 1'b1, 32'd2);
        monDiv = 2;
        rxq.delete();
        startq.delete();
        applyStimulus(A_TX, 1'b1, 32'hA5);
        applyStimulus(A_TX, 1'b1, 32'h3C);
        waitCycles(45);
        checkOutput("b2bCount", 32'(rxq.size()), 32'h2);
        if (rxq.size() == 2) begin
            checkOutput("b2bByte0", 32'(rxq[0]), 32'hA5);
            checkOutput("b2bByte1", 32'(rxq[1]), 32'h3C);
        end
        if (startq.size() == 2) checkOutput("b2bGap", 32'(startq[1] - startq[0]), 32'd20);
        else checkOutput("b2bStarts", 32'(startq.size()), 32'h2);

        // Random bursts: decoded bytes and start spacing against the written sequence.
        for (int it = 0; it < 6; it++) begin
            div = $urandom_range(1, 6);
            n = $urandom_range(1, 9);
            applyStimulus(A_BD, 1'b1, 32'(div));
            monDiv = div;
            rxq.delete();
            startq.delete();
            expBytes.delete();
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                expBytes.push_back(b);
                applyStimulus(A_TX, 1'b1, {24'h0, b});
            end
            waitCycles(n * 10 * div + 5);
            checkOutput($sformatf("rnd%0dCount", it), 32'(rxq.size()), 32'(n));
            for (int j = 0; j < n && j < rxq.size(); j++) begin
                checkOutput($sformatf("rnd%0dByte%0d", it, j), 32'(rxq[j]), 32'(expBytes[j]));
            end
            for (int j = 1; j < startq.size(); j++) begin
                checkOutput($sformatf("rnd%0dGap%0d", it, j), 32'(startq[j] - startq[j-1]), 32'(10 * div));
            end
            applyStimulus(A_ST, 1'b0, 32'h0);
            checkOutput($sformatf("rnd%0dStatus", it), bus.IOBUS_IN, 32'h0000_0004);
        end

        // Interrupt level follows empty+idle+enable.
        applyStimulus(A_BD, 1'b1, 32'd3);
        monDiv = 3;
        rxq.delete();
        applyStimulus(A_ST, 1'b1, 32'h10);
        checkOutput("irqIdleEnabled", 32'(IRQ), 32'h1);
        applyStimulus(A_TX, 1'b1, 32'h81);
        checkOutput("irqAfterPush", 32'(IRQ), 32'h0);
        for (int k = 1; k <= 31; k++) begin
            @(posedge CLK);
            #1;
            checkOutput($sformatf("irq_k%0d", k), 32'(IRQ), (k == 31) ? 32'h1 : 32'h0);
        end
        applyStimulus(A_C, 1'b0, 32'h0);
        checkOutput("readOffsetC", bus.IOBUS_IN, 32'h0);
        applyStimulus(A_ST, 1'b1, 32'h0);
        checkOutput("irqDisabled", 32'(IRQ), 32'h0);
        checkOutput("irqByte", (rxq.size() > 0) ? 32'(rxq[0]) : 32'hFFFF_FFFF, 32'h81);

        // Fill and overflow the FIFO with a slow divisor.
        applyStimulus(A_BD, 1'b1, 32'd100);
        monDiv = 100;
        for (int j = 0; j < 9; j++) applyStimulus(A_TX, 1'b1, 32'(j + 1));
        applyStimulus(A_ST, 1'b0, 32'h0);
        checkOutput("fullNoOvf", bus.IOBUS_IN, 32'h0000_0803);
        applyStimulus(A_TX, 1'b1, 32'hEE);
        applyStimulus(A_ST, 1'b0, 32'h0);
        checkOutput("overflowSet", bus.IOBUS_IN, 32'h0000_080B);
        applyStimulus(A_ST, 1'b1, 32'h8);
        applyStimulus(A_ST, 1'b0, 32'h0);
        checkOutput("overflowCleared", bus.IOBUS_IN, 32'h0000_0803);

        // Reset in the middle of bit 4 with three bytes still queued.
        applyReset();
        applyStimulus(A_BD, 1'b1, 32'd4);
        monDiv = 4;
        for (int j = 0; j < 4; j++) applyStimulus(A_TX, 1'b1, 32'hF0 + 32'(j));
        waitCycles(16);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        monDiv = 868;
        checkOutput("midResetTx", 32'(TX), 32'h1);
        applyStimulus(A_ST, 1'b0, 32'h0);
        checkOutput("midResetStatus", bus.IOBUS_IN, 32'h0000_0004);
        applyStimulus(A_BD, 1'b0, 32'h0);
        checkOutput("midResetBaud", bus.IOBUS_IN, 32'd868);
        lows = 0;
        repeat (60) begin
            @(negedge CLK);
            if (TX !== 1'b1) lows = lows + 1;
        end
        checkOutput("midResetQuietLine", 32'(lows), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
